matrix_bus_arbiter: RTL and testbench

Shares the single matrix register-file port among `num_req` coprocessor units (e.g. the matrix multiplier, matrix adder and host loader), each of which drives the usual address/type/matrix/read/write request bundle. Requesters are served round-robin, one transaction at a time. Read requests are level-held until `out_rd_ready` returns. Write requests are single-cycle pulses, captured into a per-requester one-entry write slot. The block sits between the compute units and the matrix memory controller.

---
 rtl/matrix_bus_arbiter_if.sv | 54 +++++
 rtl/matrix_bus_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_matrix_bus_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// matrix_bus_arbiter_if : requester and memory-side bundle of the matrix port arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface matrix_bus_arbiter_if #(
  parameter int num_req       = 2,
  parameter int size          = 4,
  parameter int cell_width    = 8,
  parameter int address_width = 4,
  parameter int width         = cell_width * size
);
  logic [num_req*address_width-1:0] in_req_address;
  logic [num_req*2-1:0]             in_req_type;
  logic [num_req*2-1:0]             in_req_matrix;
  logic [num_req-1:0]               in_req_read_en;
  logic [num_req-1:0]               in_req_write_en;
  logic [num_req*width-1:0]         in_req_wdata;
  logic [num_req-1:0]               out_rd_ready;
  logic [width-1:0]                 out_rd_data;
  logic [num_req-1:0]               out_wr_full;
  logic [num_req-1:0]               out_wr_overflow;
  logic [address_width-1:0]         out_mem_address;
  logic [1:0]                       out_mem_type;
  logic [1:0]                       out_mem_matrix;
  logic                             out_mem_read_en;
  logic                             out_mem_write_en;
  logic [width-1:0]                 out_mem_wdata;
  logic                             in_mem_rd_valid;
  logic [width-1:0]                 in_mem_rd_data;
  logic                             in_mem_wr_ack;

  // The arbiter itself: requests and memory responses in, everything else out.
  modport slave (
    input  in_req_address, in_req_type, in_req_matrix, in_req_read_en,
           in_req_write_en, in_req_wdata, in_mem_rd_valid, in_mem_rd_data,
           in_mem_wr_ack,
    output out_rd_ready, out_rd_data, out_wr_full, out_wr_overflow,
           out_mem_address, out_mem_type, out_mem_matrix, out_mem_read_en,
           out_mem_write_en, out_mem_wdata
  );

  modport master (
    output in_req_address, in_req_type, in_req_matrix, in_req_read_en,
           in_req_write_en, in_req_wdata, in_mem_rd_valid, in_mem_rd_data,
           in_mem_wr_ack,
    input  out_rd_ready, out_rd_data, out_wr_full, out_wr_overflow,
           out_mem_address, out_mem_type, out_mem_matrix, out_mem_read_en,
           out_mem_write_en, out_mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/matrix_bus_arbiter.sv
// ----------------------------------------------------------------------------
// matrix_bus_arbiter : round-robin sharing of the matrix register-file port
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module matrix_bus_arbiter #(
  parameter int num_req       = 2,
  parameter int size          = 4,
  parameter int cell_width    = 8,
  parameter int address_width = 4,
  parameter int width         = cell_width * size
) (
  input  logic                in_clk,
  input  logic                in_reset,
  matrix_bus_arbiter_if.slave bus
);

  localparam int c_idx_w = (num_req > 1) ? $clog2(num_req) : 1;

  typedef enum logic [1:0] {
    s_IDLE = 2'd0,
    s_WAIT = 2'd1,
    s_RESP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [c_idx_w-1:0]       grant_q, grant_d;
  logic [c_idx_w-1:0]       ptr_q, ptr_d;
  logic                     is_wr_q, is_wr_d;
  logic [address_width-1:0] mem_address_q, mem_address_d;
  logic [1:0]               mem_type_q, mem_type_d;
  logic [1:0]               mem_matrix_q, mem_matrix_d;
  logic                     mem_read_en_q, mem_read_en_d;
  logic                     mem_write_en_q, mem_write_en_d;
  logic [width-1:0]         mem_wdata_q, mem_wdata_d;
  logic [width-1:0]         rd_data_q, rd_data_d;
  logic [num_req-1:0]       rd_ready_q, rd_ready_d;

  logic [num_req-1:0]       slot_full_q, slot_full_d;
  logic [num_req-1:0]       overflow_q, overflow_d;
  logic [address_width-1:0] slot_address_q [num_req];
  logic [address_width-1:0] slot_address_d [num_req];
  logic [1:0]               slot_type_q    [num_req];
  logic [1:0]               slot_type_d    [num_req];
  logic [1:0]               slot_matrix_q  [num_req];
  logic [1:0]               slot_matrix_d  [num_req];
  logic [width-1:0]         slot_wdata_q   [num_req];
  logic [width-1:0]         slot_wdata_d   [num_req];

  logic [num_req-1:0]       slot_free;
  logic [num_req-1:0]       pending;
  logic                     found;
  logic [c_idx_w-1:0]       pick;
  logic [c_idx_w-1:0]       cand;

  // A slot frees on the edge its write acknowledge is accepted.
  always_comb begin
    slot_free = '0;
    if (state_q == s_WAIT && is_wr_q && bus.in_mem_wr_ack) begin
      slot_free[grant_q] = 1'b1;
    end
  end

  always_comb begin
    slot_full_d    = slot_full_q;
    overflow_d     = overflow_q;
    slot_address_d = slot_address_q;
    slot_type_d    = slot_type_q;
    slot_matrix_d  = slot_matrix_q;
    slot_wdata_d   = slot_wdata_q;
    for (int i = 0; i < num_req; i++) begin
      if (bus.in_req_write_en[i]) begin
        if (!slot_full_q[i] || slot_free[i]) begin
          slot_full_d[i]    = 1'b1;
          slot_address_d[i] = bus.in_req_address[i*address_width +: address_width];
          slot_type_d[i]    = bus.in_req_type[i*2 +: 2];
          slot_matrix_d[i]  = bus.in_req_matrix[i*2 +: 2];
          slot_wdata_d[i]   = bus.in_req_wdata[i*width +: width];
        end else begin
          overflow_d[i] = 1'b1;
        end
      end else if (slot_free[i]) begin
        slot_full_d[i] = 1'b0;
      end
    end
  end

  // A read from a requester that is pulsing a write this cycle is held back,
  // so the write (visible in its slot next cycle) goes to memory first.
  always_comb begin
    pending = slot_full_q | (bus.in_req_read_en & ~bus.in_req_write_en);
    found   = 1'b0;
    pick    = ptr_q;
    cand    = ptr_q;
    for (int k = 0; k < num_req; k++) begin
      cand = (cand == c_idx_w'(num_req - 1)) ? '0 : cand + c_idx_w'(1);
      if (!found && pending[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    ptr_d          = ptr_q;
    is_wr_d        = is_wr_q;
    mem_address_d  = mem_address_q;
    mem_type_d     = mem_type_q;
    mem_matrix_d   = mem_matrix_q;
    mem_read_en_d  = mem_read_en_q;
    mem_write_en_d = mem_write_en_q;
    mem_wdata_d    = mem_wdata_q;
    rd_data_d      = rd_data_q;
    rd_ready_d     = '0;
    case (state_q)
      s_IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = s_WAIT;
          if (slot_full_q[pick]) begin
            is_wr_d        = 1'b1;
            mem_address_d  = slot_address_q[pick];
            mem_type_d     = slot_type_q[pick];
            mem_matrix_d   = slot_matrix_q[pick];
            mem_wdata_d    = slot_wdata_q[pick];
            mem_write_en_d = 1'b1;
          end else begin
            is_wr_d       = 1'b0;
            mem_address_d = bus.in_req_address[int'(pick)*address_width +: address_width];
            mem_type_d    = bus.in_req_type[int'(pick)*2 +: 2];
            mem_matrix_d  = bus.in_req_matrix[int'(pick)*2 +: 2];
            mem_read_en_d = 1'b1;
          end
        end
      end
      s_WAIT: begin
        if (is_wr_q) begin
          if (bus.in_mem_wr_ack) begin
            mem_write_en_d = 1'b0;
            state_d        = s_RESP;
          end
        end else if (bus.in_mem_rd_valid) begin
          rd_data_d           = bus.in_mem_rd_data;
          mem_read_en_d       = 1'b0;
          rd_ready_d[grant_q] = 1'b1;
          state_d             = s_RESP;
        end
      end
      s_RESP: begin
        ptr_d   = grant_q;
        state_d = s_IDLE;
      end
      default: state_d = s_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q        <= s_IDLE;
      grant_q        <= '0;
      ptr_q          <= '0;
      is_wr_q        <= 1'b0;
      mem_address_q  <= '0;
      mem_type_q     <= '0;
      mem_matrix_q   <= '0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_wdata_q    <= '0;
      rd_data_q      <= '0;
      rd_ready_q     <= '0;
      slot_full_q    <= '0;
      overflow_q     <= '0;
      for (int i = 0; i < num_req; i++) begin
        slot_address_q[i] <= '0;
        slot_type_q[i]    <= '0;
        slot_matrix_q[i]  <= '0;
        slot_wdata_q[i]   <= '0;
      end
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      ptr_q          <= ptr_d;
      is_wr_q        <= is_wr_d;
      mem_address_q  <= mem_address_d;
      mem_type_q     <= mem_type_d;
      mem_matrix_q   <= mem_matrix_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
      mem_wdata_q    <= mem_wdata_d;
      rd_data_q      <= rd_data_d;
      rd_ready_q     <= rd_ready_d;
      slot_full_q    <= slot_full_d;
      overflow_q     <= overflow_d;
      slot_address_q <= slot_address_d;
      slot_type_q    <= slot_type_d;
      slot_matrix_q  <= slot_matrix_d;
      slot_wdata_q   <= slot_wdata_d;
    end
  end

  assign bus.out_rd_ready     = rd_ready_q;
  assign bus.out_rd_data      = rd_data_q;
  assign bus.out_wr_full      = slot_full_q;
  assign bus.out_wr_overflow  = overflow_q;
  assign bus.out_mem_address  = mem_address_q;
  assign bus.out_mem_type     = mem_type_q;
  assign bus.out_mem_matrix   = mem_matrix_q;
  assign bus.out_mem_read_en  = mem_read_en_q;
  assign bus.out_mem_write_en = mem_write_en_q;
  assign bus.out_mem_wdata    = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_matrix_bus_arbiter : scenario tasks with a queue scoreboard for the arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_matrix_bus_arbiter;
  localparam int num_req       = 2;
  localparam int size          = 4;
  localparam int cell_width    = 8;
  localparam int address_width = 4;
  localparam int width         = cell_width * size;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [1:0]  typ;
    logic [1:0]  mat;
    logic [31:0] data;
  } issue_t;

  typedef struct packed {
    logic [1:0]  rdy;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  issue_t issue_q[$];
  resp_t  resp_q[$];

  always #5 clk = ~clk;

  matrix_bus_arbiter_if #(
    .num_req(num_req), .size(size), .cell_width(cell_width),
    .address_width(address_width), .width(width)
  ) bus ();

  matrix_bus_arbiter #(
    .num_req(num_req), .size(size), .cell_width(cell_width),
    .address_width(address_width), .width(width)
  ) dut (
    .in_clk  (clk),
    .in_reset(rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mem(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (bus.out_mem_read_en || bus.out_mem_write_en) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (|bus.out_rd_ready) ok = 1'b1;
      else tick();
    end
  endtask

  function automatic issue_t observed(input issue_t exp_i);
    return {bus.out_mem_read_en, bus.out_mem_write_en, bus.out_mem_address,
            bus.out_mem_type, bus.out_mem_matrix,
            (exp_i.wr ? bus.out_mem_wdata : 32'h0)};
  endfunction

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({bus.out_rd_ready, bus.out_wr_full, bus.out_wr_overflow} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0", {bus.out_rd_ready, bus.out_wr_full, bus.out_wr_overflow});
    end
    total++;
    if (bus.out_rd_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_rd_data got=%h exp=0", bus.out_rd_data);
    end
    total++;
    if ({bus.out_mem_read_en, bus.out_mem_write_en, bus.out_mem_address, bus.out_mem_type,
         bus.out_mem_matrix, bus.out_mem_wdata} !== 42'h0) begin
      bad++;
      $display("FAIL reset_mem got=%b%b a=%h t=%b m=%b d=%h exp=0", bus.out_mem_read_en,
               bus.out_mem_write_en, bus.out_mem_address, bus.out_mem_type, bus.out_mem_matrix,
               bus.out_mem_wdata);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    total++;
    if ({bus.out_mem_read_en, bus.out_mem_write_en} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset got=%b exp=00", {bus.out_mem_read_en, bus.out_mem_write_en});
    end
  endtask

  task automatic test_single_read();
    issue_t exp_i;
    resp_t  exp_r;
    bus.in_req_address[3:0] = 4'd4;
    bus.in_req_type[1:0]    = 2'b01;
    bus.in_req_matrix[1:0]  = 2'b00;
    bus.in_req_read_en      = 2'b01;
    issue_q.push_back(issue_t'{1'b1, 1'b0, 4'd4, 2'b01, 2'b00, 32'h0});
    resp_q.push_back(resp_t'{2'b01, 32'hDEADBEEF});
    tick();
    exp_i = issue_q.pop_front();
    total++;
    if (observed(exp_i) !== exp_i) begin
      bad++;
      $display("FAIL single_issue got=%h exp=%h", observed(exp_i), exp_i);
    end
    bus.in_mem_rd_valid = 1'b1;
    bus.in_mem_rd_data  = 32'hDEADBEEF;
    tick();
    bus.in_mem_rd_valid = 1'b0;
    bus.in_mem_rd_data  = '0;
    exp_r = resp_q.pop_front();
    total++;
    if ({bus.out_rd_ready, bus.out_rd_data, bus.out_mem_read_en} !== {exp_r, 1'b0}) begin
      bad++;
      $display("FAIL single_resp got=%b/%h/%b exp=%b/%h/0", bus.out_rd_ready, bus.out_rd_data,
               bus.out_mem_read_en, exp_r.rdy, exp_r.data);
    end
    bus.in_req_read_en = 2'b00;
    tick();
    total++;
    if ({bus.out_rd_ready, bus.out_rd_data} !== {2'b00, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL single_hold got=%b/%h exp=00/deadbeef", bus.out_rd_ready, bus.out_rd_data);
    end
  endtask

  task automatic test_contention();
    issue_t exp_i;
    resp_t  exp_r;
    bit     ok;
    logic [1:0] extra;
    bus.in_req_address = {4'd7, 4'd2};
    bus.in_req_type    = {2'b10, 2'b00};
    bus.in_req_matrix  = {2'b10, 2'b01};
    bus.in_req_read_en = 2'b11;
    issue_q.push_back(issue_t'{1'b1, 1'b0, 4'd7, 2'b10, 2'b10, 32'h0});
    issue_q.push_back(issue_t'{1'b1, 1'b0, 4'd2, 2'b00, 2'b01, 32'h0});
    resp_q.push_back(resp_t'{2'b10, 32'hA5A5A507});
    resp_q.push_back(resp_t'{2'b01, 32'hA5A5A502});
    for (int t = 0; t < 2; t++) begin
      wait_mem(ok);
      exp_i = issue_q.pop_front();
      total++;
      if (!ok || observed(exp_i) !== exp_i) begin
        bad++;
        $display("FAIL contention_issue%0d got=%h exp=%h", t, observed(exp_i), exp_i);
      end
      bus.in_mem_rd_valid = 1'b1;
      bus.in_mem_rd_data  = 32'hA5A5A500 | 32'(bus.out_mem_address);
      tick();
      bus.in_mem_rd_valid = 1'b0;
      wait_rdy(ok);
      exp_r = resp_q.pop_front();
      total++;
      if (!ok || {bus.out_rd_ready, bus.out_rd_data} !== exp_r) begin
        bad++;
        $display("FAIL contention_resp%0d got=%b/%h exp=%b/%h", t, bus.out_rd_ready,
                 bus.out_rd_data, exp_r.rdy, exp_r.data);
      end
      bus.in_req_read_en = bus.in_req_read_en & ~bus.out_rd_ready;
      tick();
    end
    extra = '0;
    repeat (4) begin
      extra = extra | bus.out_rd_ready;
      tick();
    end
    total++;
    if (extra !== 2'b00) begin
      bad++;
      $display("FAIL contention_extra_pulse got=%b exp=00", extra);
    end
  endtask

  task automatic test_write_then_read();
    issue_t exp_i;
    resp_t  exp_r;
    bit     ok;
    bus.in_req_address[3:0] = 4'd5;
    bus.in_req_type[1:0]    = 2'b00;
    bus.in_req_matrix[1:0]  = 2'b10;
    bus.in_req_wdata[31:0]  = 32'h12345678;
    bus.in_req_write_en     = 2'b01;
    bus.in_req_read_en      = 2'b01;
    issue_q.push_back(issue_t'{1'b0, 1'b1, 4'd5, 2'b00, 2'b10, 32'h12345678});
    issue_q.push_back(issue_t'{1'b1, 1'b0, 4'd5, 2'b00, 2'b10, 32'h0});
    resp_q.push_back(resp_t'{2'b01, 32'hA5A5A505});
    tick();
    bus.in_req_write_en = 2'b00;
    total++;
    if ({bus.out_wr_full, bus.out_mem_read_en, bus.out_mem_write_en} !== 4'b0100) begin
      bad++;
      $display("FAIL wr_capture got=%b exp=0100", {bus.out_wr_full, bus.out_mem_read_en, bus.out_mem_write_en});
    end
    tick();
    exp_i = issue_q.pop_front();
    total++;
    if (observed(exp_i) !== exp_i) begin
      bad++;
      $display("FAIL wr_issue got=%h exp=%h", observed(exp_i), exp_i);
    end
    repeat (2) tick();
    bus.in_mem_wr_ack = 1'b1;
    tick();
    bus.in_mem_wr_ack = 1'b0;
    total++;
    if ({bus.out_wr_full, bus.out_rd_ready, bus.out_mem_write_en} !== 5'b0) begin
      bad++;
      $display("FAIL wr_release got=%b exp=00000", {bus.out_wr_full, bus.out_rd_ready, bus.out_mem_write_en});
    end
    wait_mem(ok);
    exp_i = issue_q.pop_front();
    total++;
    if (!ok || observed(exp_i) !== exp_i) begin
      bad++;
      $display("FAIL wr_then_rd_issue got=%h exp=%h", observed(exp_i), exp_i);
    end
    bus.in_mem_rd_valid = 1'b1;
    bus.in_mem_rd_data  = 32'hA5A5A500 | 32'(bus.out_mem_address);
    tick();
    bus.in_mem_rd_valid = 1'b0;
    wait_rdy(ok);
    exp_r = resp_q.pop_front();
    total++;
    if (!ok || {bus.out_rd_ready, bus.out_rd_data} !== exp_r) begin
      bad++;
      $display("FAIL wr_then_rd_resp got=%b/%h exp=%b/%h", bus.out_rd_ready, bus.out_rd_data,
               exp_r.rdy, exp_r.data);
    end
    bus.in_req_read_en = 2'b00;
    tick();
  endtask

  task automatic test_overflow();
    issue_t exp_i;
    bit     ok;
    logic   extra;
    bus.in_req_address[7:4] = 4'd3;
    bus.in_req_type[3:2]    = 2'b01;
    bus.in_req_matrix[3:2]  = 2'b01;
    bus.in_req_wdata[63:32] = 32'hCAFE0001;
    bus.in_req_write_en     = 2'b10;
    issue_q.push_back(issue_t'{1'b0, 1'b1, 4'd3, 2'b01, 2'b01, 32'hCAFE0001});
    tick();
    bus.in_req_write_en = 2'b00;
    wait_mem(ok);
    exp_i = issue_q.pop_front();
    total++;
    if (!ok || observed(exp_i) !== exp_i) begin
      bad++;
      $display("FAIL ovf_first_issue got=%h exp=%h", observed(exp_i), exp_i);
    end
    bus.in_req_wdata[63:32] = 32'hBAD00002;
    bus.in_req_write_en     = 2'b10;
    tick();
    bus.in_req_write_en = 2'b00;
    total++;
    if ({bus.out_wr_overflow, bus.out_wr_full, bus.out_mem_wdata} !== {2'b10, 2'b10, 32'hCAFE0001}) begin
      bad++;
      $display("FAIL ovf_drop got=%b/%b/%h exp=10/10/cafe0001", bus.out_wr_overflow,
               bus.out_wr_full, bus.out_mem_wdata);
    end
    repeat (3) tick();
    bus.in_mem_wr_ack = 1'b1;
    tick();
    bus.in_mem_wr_ack = 1'b0;
    total++;
    if ({bus.out_wr_overflow, bus.out_wr_full} !== 4'b1000) begin
      bad++;
      $display("FAIL ovf_after_ack got=%b exp=1000", {bus.out_wr_overflow, bus.out_wr_full});
    end
    extra = 1'b0;
    repeat (5) begin
      tick();
      extra = extra | bus.out_mem_write_en;
    end
    total++;
    if ({extra, bus.out_wr_overflow} !== 3'b010) begin
      bad++;
      $display("FAIL ovf_sticky got=%b exp=010", {extra, bus.out_wr_overflow});
    end
  endtask

  task automatic test_slow_spurious();
    issue_t exp_i;
    resp_t  exp_r;
    bit     ok;
    bus.in_req_address[3:0] = 4'd9;
    bus.in_req_type[1:0]    = 2'b10;
    bus.in_req_matrix[1:0]  = 2'b01;
    bus.in_req_read_en      = 2'b01;
    issue_q.push_back(issue_t'{1'b1, 1'b0, 4'd9, 2'b10, 2'b01, 32'h0});
    resp_q.push_back(resp_t'{2'b01, 32'hA5A5A509});
    wait_mem(ok);
    exp_i = issue_q.pop_front();
    total++;
    if (!ok || observed(exp_i) !== exp_i) begin
      bad++;
      $display("FAIL slow_issue got=%h exp=%h", observed(exp_i), exp_i);
    end
    for (int n = 0; n < 10; n++) begin
      bus.in_mem_wr_ack = (n == 3);
      tick();
      total++;
      if ({observed(exp_i), bus.out_rd_ready} !== {exp_i, 2'b00}) begin
        bad++;
        $display("FAIL slow_stable cycle=%0d got=%h/%b exp=%h/00", n, observed(exp_i),
                 bus.out_rd_ready, exp_i);
      end
    end
    bus.in_mem_wr_ack   = 1'b0;
    bus.in_mem_rd_valid = 1'b1;
    bus.in_mem_rd_data  = 32'hA5A5A500 | 32'(bus.out_mem_address);
    tick();
    bus.in_mem_rd_valid = 1'b0;
    wait_rdy(ok);
    exp_r = resp_q.pop_front();
    total++;
    if (!ok || {bus.out_rd_ready, bus.out_rd_data} !== exp_r) begin
      bad++;
      $display("FAIL slow_resp got=%b/%h exp=%b/%h", bus.out_rd_ready, bus.out_rd_data,
               exp_r.rdy, exp_r.data);
    end
    bus.in_req_read_en = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    bit   ok;
    logic [2:0] extra;
    bus.in_req_address[7:4] = 4'd1;
    bus.in_req_type[3:2]    = 2'b00;
    bus.in_req_matrix[3:2]  = 2'b00;
    bus.in_req_read_en      = 2'b10;
    wait_mem(ok);
    total++;
    if (!ok || bus.out_mem_read_en !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_issue got=%b exp=1", bus.out_mem_read_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_rd_ready, bus.out_rd_data, bus.out_wr_full, bus.out_wr_overflow,
         bus.out_mem_read_en, bus.out_mem_write_en, bus.out_mem_address, bus.out_mem_type,
         bus.out_mem_matrix, bus.out_mem_wdata} !== 80'h0) begin
      bad++;
      $display("FAIL rstmid_async got=%b/%h/%b/%b/%b%b exp=all zero", bus.out_rd_ready,
               bus.out_rd_data, bus.out_wr_full, bus.out_wr_overflow, bus.out_mem_read_en,
               bus.out_mem_write_en);
    end
    bus.in_req_read_en  = 2'b00;
    bus.in_mem_rd_valid = 1'b1;
    bus.in_mem_rd_data  = 32'h0BADF00D;
    tick();
    rst_n = 1'b1;
    extra = '0;
    repeat (6) begin
      tick();
      bus.in_mem_rd_valid = 1'b0;
      extra = extra | {bus.out_rd_ready, bus.out_mem_read_en};
    end
    total++;
    if ({extra, bus.out_rd_data} !== 35'h0) begin
      bad++;
      $display("FAIL rstmid_no_pulse got=%b/%h exp=000/0", extra, bus.out_rd_data);
    end
  endtask

  initial begin
    bus.in_req_address  = '0;
    bus.in_req_type     = '0;
    bus.in_req_matrix   = '0;
    bus.in_req_read_en  = '0;
    bus.in_req_write_en = '0;
    bus.in_req_wdata    = '0;
    bus.in_mem_rd_valid = 1'b0;
    bus.in_mem_rd_data  = '0;
    bus.in_mem_wr_ack   = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_then_read();
    test_overflow();
    test_slow_spurious();
    test_reset_mid();
    total++;
    if (issue_q.size() != 0 || resp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover issues=%0d resps=%0d exp=0/0", issue_q.size(), resp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
